jts16b_mcu_xfer: RTL and testbench
==================================

JTS16B_MCU_XFER -- requirements
Module: jts16b_mcu_xfer

Interface
REQ-001 Parameter: GRANT_TO, 8'd255, cpu_cen ticks allowed for a bus grant before abort.
REQ-002 clk  in  1  system clock; all logic on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 cpu_cen  in  1  68000 clock enable; gates bus-arbitration timing.
REQ-005 rd_req / wr_req  in  1/1  one-clk MCU transfer request strobes; both high counts as rd_req only.
REQ-006 req_addr / req_data  in  23/16  transfer word address [23:1] and write data.
REQ-007 wait_cyc  in  2  extra wait states for the access, 0-3, from the active region's size register.
REQ-008 halted  in  1  high while the 68000 is held in reset or halt.
REQ-009 cpu_bgn / cpu_asn  in  1/1  68000 bus grant and address strobe, both active low.
REQ-010 bus_busy  in  1  memory back end still servicing the access.
REQ-011 bus_dout  in  16  read data returned by the memory back end.
REQ-012 cpu_brn / cpu_bgackn  out  1/1  bus request and bus-grant acknowledge to the 68000, both active low.
REQ-013 bus_mcu  out  1  high while this block owns the bus; steers the mapper address/data muxes.
REQ-014 bus_asn / bus_rnw / bus_dsn  out  1/1/2  strobes driven onto the shared bus.
REQ-015 bus_addr / bus_din  out  23/16  address and write data driven onto the shared bus.
REQ-016 rd_data  out  16  last read word, held until the next read completes.
REQ-017 busy / done / err  out  1/1/1  transfer in progress; one-clk completion pulse; one-clk grant-timeout pulse.

Function
REQ-018 States SHALL be: IDLE, REQ, GRANT, ADDR, ACC, REL.
REQ-019 In IDLE, a request SHALL latch addr, data and direction, then move to GRANT if halted=1 and to REQ otherwise.
REQ-020 busy SHALL go high the clock after acceptance and stay high until done or err; requests arriving while busy SHALL be ignored.
REQ-021 In REQ, cpu_brn SHALL be 0; the block SHALL move to GRANT on a cpu_cen tick where cpu_bgn=0 and cpu_asn=1.
REQ-022 REQ SHALL count cpu_cen ticks; when the count reaches GRANT_TO, the block SHALL pulse err, release cpu_brn and return to IDLE without driving the bus.
REQ-023 A rise of halted while in REQ SHALL move the block to GRANT on the next clk.
REQ-024 In GRANT, the block SHALL set cpu_bgackn=0, cpu_brn=1 and bus_mcu=1, then move to ADDR on the next cpu_cen tick.
REQ-025 In ADDR, the block SHALL drive bus_asn=0 and bus_dsn=2'b00, set bus_rnw=1 for reads and 0 for writes, and drive bus_addr/bus_din from the latches.
REQ-026 ADDR SHALL hold for wait_cyc+1 cpu_cen ticks (1-4), then move to ACC; wait_cyc SHALL be sampled on entry to ADDR.
REQ-027 ACC SHALL keep all strobes asserted and move to REL once bus_busy has been 0 on two consecutive clks.
REQ-028 On leaving ACC after a read, rd_data SHALL capture bus_dout.
REQ-029 In REL, bus_asn SHALL be 1 immediately; after one cpu_cen tick cpu_bgackn SHALL be 1, done SHALL pulse, and the block SHALL return to IDLE.
REQ-030 bus_mcu SHALL fall with cpu_bgackn unless halted=1, in which case it SHALL stay high until halted falls while in IDLE.
REQ-031 When bus_mcu=0: bus_asn SHALL be 1, bus_rnw 1, bus_dsn 2'b11, and bus_addr/bus_din SHALL hold their last values.
REQ-032 Wait and timeout counters SHALL saturate and never wrap.

Reset
REQ-033 On rst_n=0, the block SHALL go to IDLE with cpu_brn=1, cpu_bgackn=1, bus_mcu=0, bus_asn=1, bus_rnw=1, bus_dsn=2'b11, busy=0, done=0, err=0, and rd_data, bus_addr, bus_din all 0.
REQ-034 A reset during any state SHALL abort the transfer without a done or err pulse.

Structure
REQ-035 The state encoding and the GRANT_TO default SHALL live in the shared jts16b package.
REQ-036 The block SHALL be a single module with no sub-modules; the mapper instantiates it in place of its inline MCU bus logic.

Verification
REQ-037 Read with halted=0, cpu_bgn=0 two ticks after cpu_brn falls, wait_cyc=2, bus_dout=16'hBEEF -> exactly three ADDR ticks, rd_data=16'hBEEF, one done pulse.
REQ-038 Write to 23'h7F0010 of data 16'h1234 with halted=1 -> cpu_brn is never asserted, bus_rnw=0 during ADDR/ACC, and bus_mcu stays 1 after done.
REQ-039 cpu_bgn held at 1 -> err pulses on the 255th cpu_cen tick, cpu_brn returns to 1, and bus_asn is never 0.
REQ-040 bus_busy toggling 1-0-1-0-0 in ACC -> REL is entered only after the double 0.
REQ-041 wr_req asserted while busy=1 -> ignored; no second done pulse.
REQ-042 rst_n pulsed low during ACC -> all outputs at reset values at once, and no done pulse.

Source files
------------

// File: rtl/jts16b_mcu_xfer_pkg.sv
// Shared definitions for the MCU bus-transfer block of the System 16B mapper.
// Holds the transfer FSM encoding and the default bus-grant timeout.
package jts16b_mcu_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_GRANT = 3'd2,
        ST_ADDR  = 3'd3,
        ST_ACC   = 3'd4,
        ST_REL   = 3'd5
    } xfer_state_t;

    // Number of cpu_cen ticks to wait for a bus grant before aborting.
    localparam logic [7:0] GRANT_TO_DEF = 8'd255;

endpackage

// File: rtl/jts16b_mcu_xfer.sv
// jts16b_mcu_xfer
// Takes one-clock read/write requests from the MCU, arbitrates the 68000 bus
// (BR/BG/BGACK), runs a single word access on the shared bus and hands the bus
// back. If the 68000 is halted the arbitration handshake is skipped and the bus
// stays owned by the MCU until the halt is lifted.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_cen               68000 clock enable, paces arbitration and wait states
//   rd_req, wr_req        request strobes (rd_req wins when both are high)
//   req_addr, req_data    word address [23:1] and write data
//   wait_cyc              extra wait states (0-3) for the access
//   halted                68000 held in reset/halt
//   cpu_bgn, cpu_asn      68000 bus grant / address strobe (active low)
//   bus_busy, bus_dout    memory back-end busy flag and read data
//   cpu_brn, cpu_bgackn   bus request / grant acknowledge (active low)
//   bus_mcu               MCU owns the bus (mapper mux select)
//   bus_asn/rnw/dsn       shared-bus strobes
//   bus_addr, bus_din     shared-bus address and write data
//   rd_data               last word read
//   busy, done, err       in progress, completion pulse, grant-timeout pulse
//   st_dbg                current FSM state
//
// Handshake: a request is taken only in IDLE on the clock it is high; busy rises
// on the next clock and drops on the same clock that done or err pulses.
module jts16b_mcu_xfer
    import jts16b_mcu_xfer_pkg::*;
#(
    parameter logic [7:0] GRANT_TO = GRANT_TO_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cen,
    input  logic        rd_req,
    input  logic        wr_req,
    input  logic [22:0] req_addr,
    input  logic [15:0] req_data,
    input  logic [1:0]  wait_cyc,
    input  logic        halted,
    input  logic        cpu_bgn,
    input  logic        cpu_asn,
    input  logic        bus_busy,
    input  logic [15:0] bus_dout,
    output logic        cpu_brn,
    output logic        cpu_bgackn,
    output logic        bus_mcu,
    output logic        bus_asn,
    output logic        bus_rnw,
    output logic [1:0]  bus_dsn,
    output logic [22:0] bus_addr,
    output logic [15:0] bus_din,
    output logic [15:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output xfer_state_t st_dbg
);

    xfer_state_t state_q, state_d;
    logic [22:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        rnw_q, rnw_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [7:0]  to_cnt_q, to_cnt_d;
    logic [1:0]  wait_q, wait_d;
    logic        zero_q, zero_d;      // bus_busy was low on the previous clk in ACC
    logic        hold_q, hold_d;      // keep bus after release while halted
    logic [15:0] rd_data_q, rd_data_d;
    logic [22:0] bus_addr_q, bus_addr_d;
    logic [15:0] bus_din_q, bus_din_d;

    logic in_bus;
    logic strobe;
    logic to_hit;

    // Timeout reached on this tick; 9-bit compare so GRANT_TO=0 cannot wrap.
    assign to_hit = ({1'b0, to_cnt_q} + 9'd1) >= {1'b0, GRANT_TO};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            rnw_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            to_cnt_q   <= '0;
            wait_q     <= '0;
            zero_q     <= 1'b0;
            hold_q     <= 1'b0;
            rd_data_q  <= '0;
            bus_addr_q <= '0;
            bus_din_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rnw_q      <= rnw_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            to_cnt_q   <= to_cnt_d;
            wait_q     <= wait_d;
            zero_q     <= zero_d;
            hold_q     <= hold_d;
            rd_data_q  <= rd_data_d;
            bus_addr_q <= bus_addr_d;
            bus_din_q  <= bus_din_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rnw_d      = rnw_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        to_cnt_d   = to_cnt_q;
        wait_d     = wait_q;
        zero_d     = 1'b0;
        hold_d     = hold_q & halted;
        rd_data_d  = rd_data_q;
        bus_addr_d = bus_addr_q;
        bus_din_d  = bus_din_q;

        case (state_q)
            ST_IDLE: begin
                if (rd_req || wr_req) begin
                    addr_d   = req_addr;
                    data_d   = req_data;
                    rnw_d    = rd_req;
                    busy_d   = 1'b1;
                    to_cnt_d = '0;
                    state_d  = halted ? ST_GRANT : ST_REQ;
                end
            end
            ST_REQ: begin
                // A halted 68000 cannot answer BR, so take the bus directly.
                if (halted) begin
                    state_d = ST_GRANT;
                end else if (cpu_cen) begin
                    if (!cpu_bgn && cpu_asn) begin
                        state_d = ST_GRANT;
                    end else if (to_hit) begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else if (to_cnt_q != 8'hFF) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                end
            end
            ST_GRANT: begin
                if (cpu_cen) begin
                    wait_d     = wait_cyc;
                    bus_addr_d = addr_q;
                    bus_din_d  = data_q;
                    state_d    = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (cpu_cen) begin
                    if (wait_q == 2'd0) begin
                        state_d = ST_ACC;
                    end else begin
                        wait_d = wait_q - 2'd1;
                    end
                end
            end
            ST_ACC: begin
                zero_d = !bus_busy;
                if (!bus_busy && zero_q) begin
                    state_d = ST_REL;
                    if (rnw_q) begin
                        rd_data_d = bus_dout;
                    end
                end
            end
            ST_REL: begin
                if (cpu_cen) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    hold_d  = halted;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign in_bus = (state_q == ST_GRANT) || (state_q == ST_ADDR) ||
                    (state_q == ST_ACC)   || (state_q == ST_REL);
    assign strobe = (state_q == ST_ADDR) || (state_q == ST_ACC);

    assign cpu_brn    = (state_q != ST_REQ);
    assign cpu_bgackn = !in_bus;
    assign bus_mcu    = in_bus || hold_q;
    assign bus_asn    = !strobe;
    assign bus_rnw    = strobe ? rnw_q : 1'b1;
    assign bus_dsn    = strobe ? 2'b00 : 2'b11;
    assign bus_addr   = bus_addr_q;
    assign bus_din    = bus_din_q;
    assign rd_data    = rd_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign st_dbg     = state_q;

endmodule

// File: tb/tb_jts16b_mcu_xfer.sv
module tb_jts16b_mcu_xfer;
    import jts16b_mcu_xfer_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_cen = 1'b0;
    logic        rd_req = 1'b0;
    logic        wr_req = 1'b0;
    logic [22:0] req_addr = '0;
    logic [15:0] req_data = '0;
    logic [1:0]  wait_cyc = '0;
    logic        halted = 1'b0;
    logic        cpu_bgn = 1'b1;
    logic        cpu_asn = 1'b1;
    logic        bus_busy = 1'b0;
    logic [15:0] bus_dout = '0;
    logic        cpu_brn, cpu_bgackn, bus_mcu, bus_asn, bus_rnw;
    logic [1:0]  bus_dsn;
    logic [22:0] bus_addr;
    logic [15:0] bus_din, rd_data;
    logic        busy, done, err;
    xfer_state_t st_dbg;

    always #5 clk = ~clk;
    // cpu_cen high every other clk, changed away from the rising edge
    always @(negedge clk) cpu_cen = ~cpu_cen;

    jts16b_mcu_xfer dut (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen),
        .rd_req(rd_req), .wr_req(wr_req), .req_addr(req_addr), .req_data(req_data),
        .wait_cyc(wait_cyc), .halted(halted), .cpu_bgn(cpu_bgn), .cpu_asn(cpu_asn),
        .bus_busy(bus_busy), .bus_dout(bus_dout),
        .cpu_brn(cpu_brn), .cpu_bgackn(cpu_bgackn), .bus_mcu(bus_mcu),
        .bus_asn(bus_asn), .bus_rnw(bus_rnw), .bus_dsn(bus_dsn),
        .bus_addr(bus_addr), .bus_din(bus_din), .rd_data(rd_data),
        .busy(busy), .done(done), .err(err), .st_dbg(st_dbg)
    );

    // ---------------- event monitors ----------------
    int n_done = 0, n_err = 0, n_addr_tick = 0, n_req_tick = 0;
    int n_brn_low = 0, n_asn_low = 0, n_rnw_hi_strobe = 0;

    always @(posedge clk) begin
        if (done) n_done <= n_done + 1;
        if (err) n_err <= n_err + 1;
        if (st_dbg == ST_ADDR && cpu_cen) n_addr_tick <= n_addr_tick + 1;
        if (st_dbg == ST_REQ && cpu_cen) n_req_tick <= n_req_tick + 1;
        if (!cpu_brn) n_brn_low <= n_brn_low + 1;
        if (!bus_asn) n_asn_low <= n_asn_low + 1;
        if ((st_dbg == ST_ADDR || st_dbg == ST_ACC) && bus_rnw) n_rnw_hi_strobe <= n_rnw_hi_strobe + 1;
    end

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic pulse_req(input bit rd, input bit wr, input logic [22:0] a, input logic [15:0] d);
        @(negedge clk);
        rd_req = rd; wr_req = wr; req_addr = a; req_data = d;
        @(negedge clk);
        rd_req = 1'b0; wr_req = 1'b0;
    endtask

    task automatic wait_pulse(input bit use_err, input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (use_err ? err : done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input xfer_state_t s, input int max, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (st_dbg == s) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_brn"}, cpu_brn, 1);
        chk({tag, "_bgackn"}, cpu_bgackn, 1);
        chk({tag, "_mcu"}, bus_mcu, 0);
        chk({tag, "_asn"}, bus_asn, 1);
        chk({tag, "_rnw"}, bus_rnw, 1);
        chk({tag, "_dsn"}, bus_dsn, 2'b11);
        chk({tag, "_busy_done_err"}, {busy, done, err}, 3'b000);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_addr"}, bus_addr, 0);
        chk({tag, "_din"}, bus_din, 0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit seen;
        int d0, a0, k, r0, s0, b0;

        repeat (4) @(negedge clk);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read, grant two ticks after BR, two wait states
        wait_cyc = 2'd2; bus_dout = 16'hBEEF; halted = 1'b0;
        d0 = n_done; a0 = n_addr_tick;
        pulse_req(1'b1, 1'b0, 23'h001234, 16'h0);
        chk("rd_busy_after_accept", busy, 1);
        chk("rd_brn_low", cpu_brn, 0);
        k = 0;
        for (int i = 0; i < 20 && k < 2; i++) begin
            @(posedge clk);
            if (cpu_cen) k++;
        end
        @(negedge clk);
        cpu_bgn = 1'b0;
        wait_pulse(1'b0, 200, seen);
        chk("rd_done_seen", seen, 1);
        chk("rd_busy_at_done", busy, 0);
        chk("rd_bgackn_at_done", cpu_bgackn, 1);
        cpu_bgn = 1'b1;
        repeat (10) @(negedge clk);
        chk("rd_addr_ticks", n_addr_tick - a0, 3);
        chk("rd_data", rd_data, 16'hBEEF);
        chk("rd_done_count", n_done - d0, 1);
        chk("rd_mcu_released", bus_mcu, 0);
        chk("rd_bus_addr_hold", bus_addr, 23'h001234);

        // Halted write, plus a request while busy that must be ignored
        halted = 1'b1; wait_cyc = 2'd0;
        d0 = n_done; b0 = n_brn_low; r0 = n_rnw_hi_strobe;
        pulse_req(1'b0, 1'b1, 23'h7F0010, 16'h1234);
        pulse_req(1'b0, 1'b1, 23'h000055, 16'hDEAD);
        wait_state(ST_ADDR, 50, seen);
        chk("wr_addr_seen", seen, 1);
        chk("wr_bus_addr", bus_addr, 23'h7F0010);
        chk("wr_bus_din", bus_din, 16'h1234);
        chk("wr_strobes", {bus_asn, bus_rnw, bus_dsn}, 4'b0000);
        wait_pulse(1'b0, 200, seen);
        chk("wr_done_seen", seen, 1);
        chk("wr_mcu_held", bus_mcu, 1);
        repeat (20) @(negedge clk);
        chk("wr_mcu_still_held", bus_mcu, 1);
        chk("wr_brn_never_low", n_brn_low - b0, 0);
        chk("wr_rnw_low_in_strobe", n_rnw_hi_strobe - r0, 0);
        chk("wr_single_done", n_done - d0, 1);
        chk("wr_idle_busy", busy, 0);
        halted = 1'b0;
        repeat (2) @(negedge clk);
        chk("wr_mcu_drop", bus_mcu, 0);
        chk("wr_asn_idle", bus_asn, 1);
        chk("wr_addr_hold", bus_addr, 23'h7F0010);

        // Grant never arrives: timeout
        cpu_bgn = 1'b1;
        d0 = n_done; s0 = n_asn_low; r0 = n_req_tick;
        pulse_req(1'b1, 1'b0, 23'h000100, 16'h0);
        wait_pulse(1'b1, 1500, seen);
        chk("to_err_seen", seen, 1);
        chk("to_req_ticks", n_req_tick - r0, 255);
        chk("to_busy", busy, 0);
        @(negedge clk);
        chk("to_brn_released", cpu_brn, 1);
        chk("to_asn_never_low", n_asn_low - s0, 0);
        chk("to_no_done", n_done - d0, 0);
        chk("to_state_idle", st_dbg, ST_IDLE);

        // bus_busy 1-0-1-0-0 in ACC
        cpu_bgn = 1'b0; bus_busy = 1'b1; bus_dout = 16'hA5C3; wait_cyc = 2'd1;
        pulse_req(1'b1, 1'b0, 23'h000200, 16'h0);
        wait_state(ST_ACC, 100, seen);
        chk("bb_acc_seen", seen, 1);
        bus_busy = 1'b1; @(negedge clk);
        chk("bb_step1", st_dbg, ST_ACC);
        bus_busy = 1'b0; @(negedge clk);
        chk("bb_step2", st_dbg, ST_ACC);
        bus_busy = 1'b1; @(negedge clk);
        chk("bb_step3", st_dbg, ST_ACC);
        bus_busy = 1'b0; @(negedge clk);
        chk("bb_step4", st_dbg, ST_ACC);
        @(negedge clk);
        chk("bb_step5_rel", st_dbg, ST_REL);
        chk("bb_rel_asn", bus_asn, 1);
        wait_pulse(1'b0, 20, seen);
        chk("bb_done_seen", seen, 1);
        chk("bb_rd_data", rd_data, 16'hA5C3);

        // Reset in the middle of ACC
        bus_busy = 1'b1;
        pulse_req(1'b1, 1'b0, 23'h000300, 16'h0);
        wait_state(ST_ACC, 100, seen);
        chk("rs_acc_seen", seen, 1);
        d0 = n_done;
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("rs");
        @(negedge clk);
        rst_n = 1'b1;
        bus_busy = 1'b0; cpu_bgn = 1'b1;
        repeat (20) @(negedge clk);
        chk("rs_no_done", n_done - d0, 0);
        chk("rs_state_idle", st_dbg, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop in case a wait above is mis-bounded
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
